// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter and its ALU:
//   - ALU operand/opcode widths
//   - ALU opcode constants
//   - arbiter FSM state encoding
//   - round-robin pick helper
package alu_arbiter_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OPC_W  = 4;

  localparam logic [ALU_OPC_W-1:0] OP_AND   = 4'd0;
  localparam logic [ALU_OPC_W-1:0] OP_NAND  = 4'd1;
  localparam logic [ALU_OPC_W-1:0] OP_OR    = 4'd2;
  localparam logic [ALU_OPC_W-1:0] OP_NOR   = 4'd3;
  localparam logic [ALU_OPC_W-1:0] OP_XOR   = 4'd4;
  localparam logic [ALU_OPC_W-1:0] OP_XNOR  = 4'd5;
  localparam logic [ALU_OPC_W-1:0] OP_NOT   = 4'd6;
  localparam logic [ALU_OPC_W-1:0] OP_ADD   = 4'd7;
  localparam logic [ALU_OPC_W-1:0] OP_SUB   = 4'd8;
  localparam logic [ALU_OPC_W-1:0] OP_MULT  = 4'd9;
  localparam logic [ALU_OPC_W-1:0] OP_DIV   = 4'd10;
  localparam logic [ALU_OPC_W-1:0] OP_SHIFT = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Two-way round robin: on a tie the port that did not win last time wins.
  function automatic logic arbitrate(input logic v0, input logic v1,
                                     input logic last_grant);
    if (v0 && v1) return ~last_grant;
    else if (v1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
// Purely combinational 4-bit ALU shared by the arbiter's requesters.
// Ports:
//   opcode : operation select (OP_* in alu_arbiter_pkg)
//   a, b   : operands
//   cin    : carry/borrow in (ADD, SUB)
//   out    : primary result
//   out_2  : secondary result (high product, remainder, shifted-out bits)
//   cout   : carry out (ADD) or borrow out (SUB), else 0
// SHIFT uses b[0] as direction (0 = left, 1 = right) and b[3:1] as amount.
// DIV by zero returns out = all ones, out_2 = a. Unused opcodes return 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_OPC_W-1:0]  opcode,
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  input  logic                  cin,
  output logic [ALU_DATA_W-1:0] out,
  output logic [ALU_DATA_W-1:0] out_2,
  output logic                  cout
);

  logic [ALU_DATA_W:0]       sum;
  logic [ALU_DATA_W:0]       diff;
  logic [2*ALU_DATA_W-1:0]   prod;
  logic [2*ALU_DATA_W-1:0]   shl;
  logic [2*ALU_DATA_W-1:0]   shr;

  assign sum  = {1'b0, a} + {1'b0, b} + {{ALU_DATA_W{1'b0}}, cin};
  // The borrow lands in the extra top bit of the two's-complement difference.
  assign diff = {1'b0, a} - {1'b0, b} - {{ALU_DATA_W{1'b0}}, cin};
  assign prod = {{ALU_DATA_W{1'b0}}, a} * {{ALU_DATA_W{1'b0}}, b};
  assign shl  = {{ALU_DATA_W{1'b0}}, a} << b[3:1];
  assign shr  = {a, {ALU_DATA_W{1'b0}}} >> b[3:1];

  always_comb begin
    out   = '0;
    out_2 = '0;
    cout  = 1'b0;
    case (opcode)
      OP_AND:   out = a & b;
      OP_NAND:  out = ~(a & b);
      OP_OR:    out = a | b;
      OP_NOR:   out = ~(a | b);
      OP_XOR:   out = a ^ b;
      OP_XNOR:  out = ~(a ^ b);
      OP_NOT:   out = ~a;
      OP_ADD:   {cout, out} = sum;
      OP_SUB:   {cout, out} = diff;
      OP_MULT:  {out_2, out} = prod;
      OP_DIV: begin
        if (b == '0) begin
          out   = '1;
          out_2 = a;
        end else begin
          out   = a / b;
          out_2 = a % b;
        end
      end
      OP_SHIFT: begin
        if (!b[0]) {out_2, out} = shl;
        else       {out, out_2} = shr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between two requesters via valid/ready handshakes. One op
// in flight; operands and results are registered.
// Build option: ALU_ARB_RR_EN defined -> round-robin grants; undefined ->
// fixed priority with port 0 always winning.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   reqN_valid/ready              : request handshake, N = 0/1
//   reqN_opcode/a/b/cin           : request payload
//   rspN_valid/ready              : response handshake
//   rsp_out/rsp_out_2/rsp_cout    : registered ALU results
//   rsp_id                        : requester owning the current result
//   busy                          : FSM not idle
//
//   state   | meaning
//   IDLE    | arbitrating, ready to accept one request
//   EXEC    | ALU evaluating latched operands, results load at end
//   RESP    | result held for owner until its rsp_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic [DATA_W-1:0] rsp_out_2,
  output logic              rsp_cout,
  output logic              rsp_id,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              grant;
  logic              accept;
  logic              id_r;
  logic [OPC_W-1:0]  op_opcode;
  logic [DATA_W-1:0] op_a, op_b;
  logic              op_cin;
  logic [DATA_W-1:0] alu_out, alu_out_2;
  logic              alu_cout;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  assign grant = arbitrate(req0_valid, req1_valid, last_grant);

  // Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  assign grant = ~req0_valid;
`endif

  assign accept = req0_ready | req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (id_r ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Readies are masked by rst so nothing looks accepted while held in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != ST_IDLE);
    if (state_q == ST_IDLE && !rst) begin
      req0_ready = !grant && req0_valid;
      req1_ready = grant && req1_valid;
    end
    if (state_q == ST_RESP) begin
      rsp0_valid = !id_r;
      rsp1_valid = id_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_opcode <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      id_r      <= 1'b0;
    end else if (accept) begin
      op_opcode <= grant ? req1_opcode : req0_opcode;
      op_a      <= grant ? req1_a      : req0_a;
      op_b      <= grant ? req1_b      : req0_b;
      op_cin    <= grant ? req1_cin    : req0_cin;
      id_r      <= grant;
    end
  end

  alu_arbiter_alu u_alu (
    .opcode (op_opcode),
    .a      (op_a),
    .b      (op_b),
    .cin    (op_cin),
    .out    (alu_out),
    .out_2  (alu_out_2),
    .cout   (alu_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out   <= '0;
      rsp_out_2 <= '0;
      rsp_cout  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_out   <= alu_out;
      rsp_out_2 <= alu_out_2;
      rsp_cout  <= alu_cout;
    end
  end

  assign rsp_id = id_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic compared against an arithmetic reference of the ALU and a simple
// "who wins" arbitration model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_opcode, req1_opcode, req0_a, req0_b, req1_a, req1_b;
  logic       req0_cin, req1_cin;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [3:0] rsp_out, rsp_out_2;
  logic       rsp_cout, rsp_id, busy;

  int checks = 0;
  int errors = 0;
  int exp_last = 1;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_out(rsp_out), .rsp_out_2(rsp_out_2), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  // Returns {cout, out_2, out} from integer arithmetic.
  function automatic logic [8:0] alu_ref(input logic [3:0] opc, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin);
    int ia, ib, ic, r, r2, c, v;
    ia = int'(a); ib = int'(b); ic = int'(cin);
    r = 0; r2 = 0; c = 0; v = 0;
    case (opc)
      OP_AND:   r = ia & ib;
      OP_NAND:  r = ~(ia & ib) & 15;
      OP_OR:    r = ia | ib;
      OP_NOR:   r = ~(ia | ib) & 15;
      OP_XOR:   r = ia ^ ib;
      OP_XNOR:  r = ~(ia ^ ib) & 15;
      OP_NOT:   r = ~ia & 15;
      OP_ADD:   begin v = ia + ib + ic; r = v % 16; c = (v > 15) ? 1 : 0; end
      OP_SUB:   begin v = ia - ib - ic; r = (v + 32) % 16; c = (v < 0) ? 1 : 0; end
      OP_MULT:  begin v = ia * ib; r = v % 16; r2 = v / 16; end
      OP_DIV:   begin
        if (ib == 0) begin r = 15; r2 = ia; end
        else begin r = ia / ib; r2 = ia % ib; end
      end
      OP_SHIFT: begin
        if (ib % 2 == 0) begin v = ia << (ib / 2); r = v % 16; r2 = (v / 16) % 16; end
        else begin v = (ia * 16) >> (ib / 2); r = v / 16; r2 = v % 16; end
      end
      default: ;
    endcase
    return {c[0], r2[3:0], r[3:0]};
  endfunction

  function automatic int exp_grant(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return 1 - exp_last;
`else
      return 0;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Drives one transaction through: waits for a grant, collects the
  // response, optionally stalls rsp_ready, and returns what it observed.
  task automatic serve(input int stall, output int g, output logic [8:0] res,
                       output logic id, output logic other_v, output int lat,
                       output logic rdy_after, output logic busy_exec,
                       output logic busy_after);
    g = -1; lat = 0; res = '0; id = 1'b0; other_v = 1'b0;
    rdy_after = 1'b0; busy_exec = 1'b0; busy_after = 1'b1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      #1;
      if (req0_ready) g = 0;
      else if (req1_ready) g = 1;
      else @(negedge clk);
    end
    if (g < 0) return;
    @(posedge clk); #1;
    rdy_after = req0_ready | req1_ready;
    busy_exec = busy;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if ((g == 0) ? rsp0_valid : rsp1_valid) break;
    end
    res = {rsp_cout, rsp_out_2, rsp_out};
    id = rsp_id;
    other_v = (g == 0) ? rsp1_valid : rsp0_valid;
    repeat (stall) begin @(posedge clk); #1; end
    if (g == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    busy_after = busy;
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_opcode = 0; req1_opcode = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_cin = 0; req1_cin = 0;
    repeat (2) @(negedge clk);
    obs = {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_id, rsp_cout,
           rsp_out_2, rsp_out, 4'b0};
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL reset_hold: got %b expected 0", obs); end
    rst = 1'b0; exp_last = 1;
    @(negedge clk);
    obs = {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_id, rsp_cout,
           rsp_out_2, rsp_out, 4'b0};
    checks++;
    if (obs !== 19'd0) begin errors++; $display("FAIL reset_release: got %b expected 0", obs); end
  endtask

  task automatic test_port0_and();
    int g, lat; logic [8:0] res; logic id, ov, ra, be, ba;
    req0_opcode = OP_AND; req0_a = 4'b1010; req0_b = 4'b1100; req0_cin = 0; req0_valid = 1;
    serve(0, g, res, id, ov, lat, ra, be, ba);
    req0_valid = 0;
    checks++; if (g !== 0) begin errors++; $display("FAIL p0_grant: got %0d expected 0", g); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL p0_latency: got %0d expected 2", lat); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL p0_ready_pulse: got %b expected 0", ra); end
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL p0_busy_exec: got %b expected 1", be); end
    checks++; if (res !== 9'b0_0000_1000) begin errors++; $display("FAIL p0_and_result: got %b expected 000001000", res); end
    checks++; if (id !== 1'b0) begin errors++; $display("FAIL p0_rsp_id: got %b expected 0", id); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL p0_other_valid: got %b expected 0", ov); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL p0_idle_after: got %b expected 0", ba); end
    if (g >= 0) exp_last = g;
  endtask

  task automatic test_port1_sub();
    int g, lat; logic [8:0] res; logic id, ov, ra, be, ba;
    req1_opcode = OP_SUB; req1_a = 4'd3; req1_b = 4'd5; req1_cin = 0; req1_valid = 1;
    serve(0, g, res, id, ov, lat, ra, be, ba);
    req1_valid = 0;
    checks++; if (g !== 1) begin errors++; $display("FAIL p1_grant: got %0d expected 1", g); end
    checks++; if (res !== alu_ref(OP_SUB, 4'd3, 4'd5, 1'b0)) begin errors++; $display("FAIL p1_sub_result: got %b expected %b", res, alu_ref(OP_SUB, 4'd3, 4'd5, 1'b0)); end
    checks++; if (res[8] !== 1'b1) begin errors++; $display("FAIL p1_sub_borrow: got %b expected 1", res[8]); end
    checks++; if (id !== 1'b1) begin errors++; $display("FAIL p1_rsp_id: got %b expected 1", id); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL p1_rsp0_valid: got %b expected 0", ov); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL p1_latency: got %0d expected 2", lat); end
    if (g >= 0) exp_last = g;
  endtask

  task automatic test_shift();
    int g, lat; logic [8:0] res; logic id, ov, ra, be, ba;
    req0_opcode = OP_SHIFT; req0_a = 4'b1010; req0_b = 4'b0010; req0_cin = 0; req0_valid = 1;
    serve(0, g, res, id, ov, lat, ra, be, ba);
    req0_valid = 0;
    checks++; if (res !== 9'b0_0001_0100) begin errors++; $display("FAIL shift_result: got %b expected 000010100", res); end
    if (g >= 0) exp_last = g;
  endtask

  task automatic test_alternate();
    int g, lat, eg; logic [8:0] res, er; logic id, ov, ra, be, ba;
    req0_opcode = OP_ADD;  req0_a = 4'd3; req0_b = 4'd5; req0_cin = 0;
    req1_opcode = OP_MULT; req1_a = 4'd3; req1_b = 4'd4; req1_cin = 0;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      eg = exp_grant(1'b1, 1'b1);
      er = (eg == 0) ? alu_ref(OP_ADD, 4'd3, 4'd5, 1'b0) : alu_ref(OP_MULT, 4'd3, 4'd4, 1'b0);
      serve(0, g, res, id, ov, lat, ra, be, ba);
      checks++; if (g !== eg) begin errors++; $display("FAIL alt_grant[%0d]: got %0d expected %0d", k, g, eg); end
      checks++; if (res !== er) begin errors++; $display("FAIL alt_result[%0d]: got %b expected %b", k, res, er); end
      if (g >= 0) exp_last = g;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    int g, lat; logic [8:0] res, er; logic id, ov, ra, be, ba;
    bit got;
    req0_opcode = OP_DIV; req0_a = 4'd3; req0_b = 4'd4; req0_cin = 0; req0_valid = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req0_ready) got = 1; else @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_grant: got none expected req0_ready"); end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_opcode = OP_AND; req1_a = 4'hF; req1_b = 4'h6; req1_cin = 0; req1_valid = 1;
    @(posedge clk); #1;
    er = alu_ref(OP_DIV, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_cout, rsp_out_2, rsp_out, busy, rsp0_valid, req1_ready} !== {er, 3'b110}) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got %b expected %b", i,
                 {rsp_cout, rsp_out_2, rsp_out, busy, rsp0_valid, req1_ready}, {er, 3'b110});
      end
      @(posedge clk); #1;
    end
    rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_complete: got busy %b expected 0", busy); end
    exp_last = 0;
    serve(0, g, res, id, ov, lat, ra, be, ba);
    req1_valid = 0;
    checks++; if (g !== 1) begin errors++; $display("FAIL bp_waiter_grant: got %0d expected 1", g); end
    checks++; if (res !== alu_ref(OP_AND, 4'hF, 4'h6, 1'b0)) begin errors++; $display("FAIL bp_waiter_result: got %b", res); end
    if (g >= 0) exp_last = g;
  endtask

  task automatic test_random();
    int g, lat, eg, sel; logic [8:0] res, er; logic id, ov, ra, be, ba;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sel = $urandom_range(1, 3);
      req0_opcode = 4'($urandom_range(0, 15)); req0_a = 4'($urandom); req0_b = 4'($urandom);
      req0_cin = 1'($urandom);
      req1_opcode = 4'($urandom_range(0, 15)); req1_a = 4'($urandom); req1_b = 4'($urandom);
      req1_cin = 1'($urandom);
      req0_valid = sel[0]; req1_valid = sel[1];
      eg = exp_grant(sel[0], sel[1]);
      er = (eg == 0) ? alu_ref(req0_opcode, req0_a, req0_b, req0_cin)
                     : alu_ref(req1_opcode, req1_a, req1_b, req1_cin);
      serve($urandom_range(0, 3), g, res, id, ov, lat, ra, be, ba);
      req0_valid = 0; req1_valid = 0;
      checks++; if (g !== eg) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", k, g, eg); end
      checks++; if (res !== er) begin errors++; $display("FAIL rnd_result[%0d]: got %b expected %b", k, res, er); end
      checks++; if ({id, lat} !== {eg[0], 32'd2}) begin errors++; $display("FAIL rnd_id_lat[%0d]: got id %b lat %0d expected id %0d lat 2", k, id, lat, eg); end
      if (g >= 0) exp_last = g;
    end
  endtask

  task automatic test_reset_exec();
    int g, lat; logic [8:0] res; logic id, ov, ra, be, ba;
    logic [17:0] obs;
    bit seen;
    @(negedge clk);
    req0_opcode = OP_MULT; req0_a = 4'hF; req0_b = 4'hF; req0_cin = 1;
    req1_opcode = OP_ADD;  req1_a = 4'h9; req1_b = 4'h9; req1_cin = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    obs = {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_id, rsp_cout,
           rsp_out_2, rsp_out, 3'b0};
    checks++;
    if (obs !== 18'd0) begin errors++; $display("FAIL rst_exec_outputs: got %b expected 0", obs); end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst = 1'b0; exp_last = 1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp0_valid || rsp1_valid || busy) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rst_exec_no_rsp: got activity expected none"); end
    req0_opcode = OP_XOR; req0_a = 4'h5; req0_b = 4'h3; req0_cin = 0;
    req1_opcode = OP_NOT; req1_a = 4'h5; req1_b = 4'h0; req1_cin = 0;
    req0_valid = 1; req1_valid = 1;
    serve(0, g, res, id, ov, lat, ra, be, ba);
    req0_valid = 0; req1_valid = 0;
    checks++; if (g !== 0) begin errors++; $display("FAIL rst_exec_tie: got %0d expected 0", g); end
    checks++; if (res !== alu_ref(OP_XOR, 4'h5, 4'h3, 1'b0)) begin errors++; $display("FAIL rst_exec_result: got %b", res); end
  endtask

  initial begin
    test_reset();
    test_port0_and();
    test_port1_sub();
    test_shift();
    test_alternate();
    test_backpressure();
    test_random();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
